// File: rtl/rr_arbiter8_pkg.sv
// Shared sizes, state encoding and rotating-priority search
// used by the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int N_REQ  = 8;
  localparam int IDX_W  = 3;
  localparam int HOLD_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Returns {found, index} of the first set bit at or after p,
  // wrapping modulo N_REQ.
  function automatic logic [IDX_W:0] rr_pick(
    input logic [N_REQ-1:0] r,
    input logic [IDX_W-1:0] p
  );
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W:0]     res;
    dbl = {r, r} >> p;
    rot = dbl[N_REQ-1:0];
    res = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) res = {1'b1, p + IDX_W'(j)};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter8_decoder3x8.sv
// 3-to-8 one-hot decoder with enable; all zeros when disabled.
module decoder3x8
  import rr_arbiter8_pkg::*;
(
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_sel,
  output logic [N_REQ-1:0] o_dec
);

  assign o_dec = i_en ? (N_REQ'(1) << i_sel) : '0;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with bounded hold time
// and registered one-hot grant.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_id,
  output logic             gnt_valid
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_gnt_id;
  logic [IDX_W-1:0]   r_ptr;
  logic [HOLD_W-1:0]  r_hold;

  state_t             w_state_nx;
  logic [IDX_W-1:0]   w_id_nx;
  logic [IDX_W-1:0]   w_ptr_nx;
  logic [HOLD_W-1:0]  w_hold_nx;
  logic [N_REQ-1:0]   w_cand;
  logic [IDX_W:0]     w_pick;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic               w_keep;
  logic               w_take;

  // Current holder is masked out so it rejoins at lowest priority.
  assign w_cand  = req & ~gnt;
  assign w_pick  = rr_pick(w_cand, r_ptr);
  assign w_found = w_pick[IDX_W];
  assign w_win   = w_pick[IDX_W-1:0];
  assign w_keep  = req[r_gnt_id];

  always_comb begin
    w_state_nx = r_state;
    w_id_nx    = r_gnt_id;
    w_ptr_nx   = r_ptr;
    w_hold_nx  = r_hold;
    w_take     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) w_take = 1'b1;
      end
      GRANT: begin
        if (!w_keep || r_hold == HOLD_LAST) begin
          if (w_found)     w_take     = 1'b1;
          else if (!w_keep) w_state_nx = IDLE;
        end else begin
          w_hold_nx = r_hold + HOLD_W'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
    if (w_take) begin
      w_state_nx = GRANT;
      w_id_nx    = w_win;
      w_ptr_nx   = w_win + IDX_W'(1);
      w_hold_nx  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gnt_id <= '0;
      r_ptr    <= '0;
      r_hold   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_gnt_id <= w_id_nx;
      r_ptr    <= w_ptr_nx;
      r_hold   <= w_hold_nx;
    end
  end

  assign gnt_valid = (r_state == GRANT);
  assign gnt_id    = r_gnt_id;

  decoder3x8 u_dec (
    .i_en  (gnt_valid),
    .i_sel (r_gnt_id),
    .o_dec (gnt)
  );

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter MAX_HOLD, default 15, maximum consecutive cycles one requester may hold the grant while others wait; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  8  request vector; bit i = requester i wants the shared resource.
REQ-005 gnt  output  8  one-hot grant vector, registered; all-zero when no grant.
REQ-006 gnt_id  output  3  binary index of current grantee, registered.
REQ-007 gnt_valid  output  1  high when gnt is non-zero, registered.

Function
REQ-008 Block SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one requester granted).
REQ-009 gnt SHALL always equal the 3-to-8 one-hot decode of gnt_id when gnt_valid=1, and SHALL be 8'h00 when gnt_valid=0; at most one gnt bit high in any cycle.
REQ-010 Rotating pointer ptr[2:0] SHALL hold the highest-priority index; search order ptr, ptr+1, ..., ptr+7, modulo 8 (7 wraps to 0).
REQ-011 IDLE: if req != 0, winner = first set bit in search order; next cycle state=GRANT, gnt_id=winner, gnt_valid=1 (latency one cycle req->gnt); if req == 0, remain IDLE.
REQ-012 On every new grant, ptr SHALL load winner+1 mod 8 and hold counter hold_cnt SHALL clear to 0.
REQ-013 GRANT: while req[gnt_id]=1 and hold_cnt < MAX_HOLD-1, grant SHALL remain unchanged; hold_cnt increments each cycle.
REQ-014 GRANT release: when req[gnt_id]=0, if any other req bit set, next cycle grant SHALL move directly to next winner (no idle gap); otherwise next cycle state=IDLE, gnt=0, gnt_valid=0.
REQ-015 GRANT timeout: when hold_cnt = MAX_HOLD-1 and any other req bit set, next cycle grant SHALL move to next winner even if req[gnt_id]=1.
REQ-016 Timeout with no other requester: grant SHALL remain, hold_cnt SHALL saturate at MAX_HOLD-1 until a competitor appears or holder releases.
REQ-017 Current grantee SHALL be excluded from winner search on release/timeout; it rejoins at lowest priority.
REQ-018 Simultaneous release and new requests in same cycle: winner SHALL be computed from that cycle's req with current ptr.
REQ-019 MAX_HOLD=1: grant SHALL rotate every cycle while two or more requesters are active.

Reset
REQ-020 When rst=1 at a clock edge: state=IDLE, gnt=8'h00, gnt_id=3'd0, gnt_valid=0, ptr=3'd0, hold_cnt=0.
REQ-021 rst asserted mid-grant SHALL drop gnt on the next edge; req ignored while rst=1; first grant possible one cycle after rst deasserts.

Structure
REQ-022 Shared package/include SHALL hold: requester count 8, index width 3, FSM state encoding (IDLE=0, GRANT=1), hold counter width 4.
REQ-023 gnt SHALL be produced by one instance of the existing decoder3x8 sub-module driven from registered gnt_id, gated by gnt_valid.
REQ-024 Winner search SHALL be combinational priority logic over req rotated by ptr; all outputs flop-driven or decoded from flops only.

Verification
REQ-025 Reset then req=8'h00 for 5 cycles -> gnt=00, gnt_valid=0, gnt_id=0 throughout.
REQ-026 From reset, req=8'h81 held -> cycle+1 gnt=01 (id 0); holder drops req[0] -> next cycle gnt=80 (id 7), ptr=0; drop req[7] -> gnt=00.
REQ-027 req=8'hFF held, MAX_HOLD=15 -> grants 01,02,04,...,80,01 each held exactly 15 cycles; wrap 7->0 verified.
REQ-028 req=8'h04 held alone for 40 cycles -> gnt=04 continuous (saturation); assert req[1] -> gnt moves to 02 one cycle after hold_cnt reached 14.
REQ-029 rst pulsed while gnt=10 with req=8'h30 -> gnt=00 next edge; after rst low, gnt=10 (ptr reset to 0, search from 0 finds 4).
REQ-030 Random req for 10k cycles -> checker: gnt one-hot or zero, gnt==decode(gnt_id) when valid, no requester starved beyond 7*MAX_HOLD+8 cycles.
